beat_interval_meter: RTL and testbench

Downstream consumer of the FIR filter output. Takes one filtered 10-bit sample per `sample_valid` strobe, detects beats with a hysteresis threshold pair and a refractory window, measures beat-to-beat interval in samples, and keeps a 4-interval running average for the rate display/MCU readback path.

---
 rtl/beat_interval_meter_if.sv | 27 ++
 rtl/beat_interval_meter.sv | 174 +++++++++++++++++
 tb/tb_beat_interval_meter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beat_interval_meter_if.sv
// Sample/threshold inputs and beat/interval results for beat_interval_meter.
// The producer side (filter glue or testbench) uses master.
// The meter itself uses slave.
interface beat_interval_meter_if #(
   parameter int DW = 10,
   parameter int CW = 16
);
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic [DW-1:0] thresh_hi;
   logic [DW-1:0] thresh_lo;
   logic          beat;
   logic [CW-1:0] interval;
   logic [CW-1:0] avg_interval;
   logic          avg_valid;
   logic          timeout;

   modport master (
      output sample_valid, sample, thresh_hi, thresh_lo,
      input  beat, interval, avg_interval, avg_valid, timeout
   );

   modport slave (
      input  sample_valid, sample, thresh_hi, thresh_lo,
      output beat, interval, avg_interval, avg_valid, timeout
   );
endinterface

// File: rtl/beat_interval_meter.sv
// Beat detector and beat-to-beat interval meter for the filtered sample stream.
// It uses a hysteresis threshold pair: the stream must drop to thresh_lo
// before a rise to thresh_hi counts as a beat.
// After each beat, a refractory window ignores the next REFRACT valid samples.
// Intervals are counted in valid samples, and the last four are averaged.
// A saturating counter flags loss of signal and restarts the history.
module beat_interval_meter #(
   parameter int DW      = 10,
   parameter int CW      = 16,
   parameter int REFRACT = 50
) (
   input  logic                 clk,
   input  logic                 reset,
   beat_interval_meter_if.slave bus
);

   localparam int              RW         = $clog2(REFRACT + 1);
   localparam int              SW         = CW + 2;
   localparam logic [CW-1:0]   CNT_MAX    = '1;
   localparam logic [RW-1:0]   REFRACT_LD = RW'(REFRACT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_REFRACT
   } state_t;

   state_t                 state_q, state_d;
   logic [RW-1:0]          rcnt_q, rcnt_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   first_q, first_d;
   logic                   timeout_q, timeout_d;
   logic                   beat_q, beat_d;
   logic [CW-1:0]          interval_q, interval_d;
   logic [3:0][CW-1:0]     hist_q, hist_d;
   logic [2:0]             fill_q, fill_d;
   logic                   avg_valid_q, avg_valid_d;
   logic [CW-1:0]          avg_q, avg_d;
   logic                   beat_now;
   logic                   to_evt;

   // Interval counter step: holds at all-ones so a lost signal stays timed out.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   // Mean of the four history entries.
   // The sum is two bits wider than an entry and the mean is truncated.
   function automatic logic [CW-1:0] trunc_avg(input logic [3:0][CW-1:0] h);
      logic [SW-1:0] sum;
      sum = SW'(h[0]) + SW'(h[1]) + SW'(h[2]) + SW'(h[3]);
      return sum[SW-1:2];
   endfunction

   // Detector FSM next state: at most one transition per valid sample.
   always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      beat_now = 1'b0;
      if (bus.sample_valid) begin
         case (state_q)
            S_IDLE: begin
               // Re-arm only once the signal has fallen back to baseline.
               if (bus.sample <= bus.thresh_lo) begin
                  state_d = S_ARMED;
               end
            end
            S_ARMED: begin
               if (bus.sample >= bus.thresh_hi) begin
                  beat_now = 1'b1;
                  state_d  = S_REFRACT;
                  rcnt_d   = REFRACT_LD;
               end
            end
            S_REFRACT: begin
               // The sample that brings the window to zero is still ignored.
               rcnt_d = rcnt_q - RW'(1);
               if (rcnt_q == RW'(1)) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Interval counting, first-beat suppression, history shift and timeout.
   always_comb begin
      cnt_d      = cnt_q;
      first_d    = first_q;
      timeout_d  = timeout_q;
      interval_d = interval_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      beat_d     = 1'b0;
      to_evt     = 1'b0;
      if (bus.sample_valid) begin
         beat_d = beat_now;
         if (beat_now) begin
            cnt_d = '0;
            if (first_q) begin
               // No earlier beat to measure from: just start timing.
               first_d   = 1'b0;
               timeout_d = 1'b0;
            end else begin
               // cnt counts the samples strictly between the two beats.
               interval_d = cnt_q + CW'(1);
               hist_d     = {hist_q[2:0], interval_d};
               fill_d     = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            end
         end else begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_q == CNT_MAX - CW'(1)) begin
               // Signal lost: the next beat starts a fresh measurement.
               to_evt    = 1'b1;
               timeout_d = 1'b1;
               first_d   = 1'b1;
               hist_d    = '0;
               fill_d    = '0;
            end
         end
      end
   end

   // Averager feeding the registered adder stage.
   // It follows the history by one cycle, but a timeout clears it at once.
   always_comb begin
      avg_valid_d = (fill_q == 3'd4);
      avg_d       = avg_valid_d ? trunc_avg(hist_q) : '0;
      if (to_evt) begin
         avg_valid_d = 1'b0;
         avg_d       = '0;
      end
   end

   // State registers.
   // Reset dominates everything, including a coincident sample_valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rcnt_q      <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         timeout_q   <= 1'b0;
         beat_q      <= 1'b0;
         interval_q  <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         avg_valid_q <= 1'b0;
         avg_q       <= '0;
      end else begin
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         timeout_q   <= timeout_d;
         beat_q      <= beat_d;
         interval_q  <= interval_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         avg_valid_q <= avg_valid_d;
         avg_q       <= avg_d;
      end
   end

   assign bus.beat         = beat_q;
   assign bus.interval     = interval_q;
   assign bus.avg_interval = avg_q;
   assign bus.avg_valid    = avg_valid_q;
   assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_beat_interval_meter.sv
// Testbench for beat_interval_meter.
// Randomized sample streams are run against a sample-level behavioural model.
// CW is reduced to 8 so that a timeout is reachable in a few hundred samples.
module tb_beat_interval_meter;
   localparam int DW      = 10;
   localparam int CW      = 8;
   localparam int REFRACT = 50;
   localparam int MAXC    = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;

   beat_interval_meter_if #(.DW(DW), .CW(CW)) bus ();

   beat_interval_meter #(.DW(DW), .CW(CW), .REFRACT(REFRACT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int dev_cnt, dut_beats, mdl_beats;
   longint dev_t;
   int lo = 200;
   int hi = 600;

   // behavioural model state
   bit   m_armed;
   int   m_quiet;   // valid samples still ignored after a beat
   int   m_since;   // valid samples since last beat (saturating at MAXC)
   bit   m_first;
   bit   m_to;
   int   m_int;
   int   hist[$];   // last (up to) 4 recorded intervals

   function automatic int hist_avg();
      int s;
      s = 0;
      if (hist.size() < 4) return 0;
      foreach (hist[i]) s += hist[i];
      return s >> 2;
   endfunction

   task automatic model_reset();
      m_armed = 0; m_quiet = 0; m_since = 0; m_first = 1; m_to = 0; m_int = 0;
      hist.delete();
   endtask

   task automatic model_sample(input int s, output bit b, output bit tev);
      b = 0; tev = 0;
      if (m_quiet > 0) m_quiet--;
      else if (!m_armed) begin
         if (s <= lo) m_armed = 1;
      end else if (s >= hi) begin
         b = 1; m_armed = 0; m_quiet = REFRACT;
      end
      if (b) begin
         if (m_first) begin
            m_first = 0; m_to = 0;
         end else begin
            m_int = m_since + 1;
            hist.push_back(m_int);
            if (hist.size() > 4) void'(hist.pop_front());
         end
         m_since = 0;
      end else if (m_since < MAXC) begin
         m_since++;
         if (m_since == MAXC) begin
            tev = 1; m_to = 1; m_first = 1; hist.delete();
         end
      end
   endtask

   // One clock: drive, advance model, record whether the DUT diverged.
   task automatic step(input bit v, input int s);
      bit mb, tev, pv;
      int pa;
      @(negedge clk);
      reset = 1'b1;
      bus.sample_valid = v;
      bus.sample = DW'(s);
      pv = (hist.size() >= 4);
      pa = hist_avg();
      mb = 0; tev = 0;
      if (v) model_sample(s, mb, tev);
      @(posedge clk);
      #1;
      if (bus.beat === 1'b1) dut_beats++;
      if (mb) mdl_beats++;
      if (bus.beat !== mb || bus.interval !== CW'(m_int) || bus.timeout !== m_to ||
          bus.avg_valid !== (pv && !tev) || bus.avg_interval !== CW'(tev ? 0 : pa)) begin
         if (dev_cnt == 0) dev_t = $time;
         dev_cnt++;
      end
   endtask

   task automatic rst_cycle(input bit v);
      @(negedge clk);
      reset = 1'b0;
      bus.sample_valid = v;
      bus.sample = '1;
      @(posedge clk);
      #1;
      model_reset();
      if ({bus.beat, bus.interval, bus.avg_interval, bus.avg_valid, bus.timeout} !== '0) begin
         if (dev_cnt == 0) dev_t = $time;
         dev_cnt++;
      end
   endtask

   task automatic do_reset(input int n);
      dev_cnt = 0; dut_beats = 0; mdl_beats = 0;
      bus.thresh_lo = DW'(lo);
      bus.thresh_hi = DW'(hi);
      for (int i = 0; i < n; i++) rst_cycle(i[0]);
   endtask

   task automatic base(input int n);
      for (int i = 0; i < n; i++) step(1, $urandom_range(0, lo));
   endtask

   task automatic peak();
      step(1, $urandom_range(hi, 1023));
   endtask

   task automatic gstep(input int s);
      for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1023));
      step(1, s);
   endtask

   task automatic test_reset();
      lo = 200; hi = 600;
      do_reset(3);
      checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL reset_beat got %0b want 0", bus.beat); end
      checks++; if (bus.interval !== '0) begin errors++; $display("FAIL reset_interval got %0d want 0", bus.interval); end
      checks++; if (bus.avg_interval !== '0) begin errors++; $display("FAIL reset_avg got %0d want 0", bus.avg_interval); end
      checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid got %0b want 0", bus.avg_valid); end
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", bus.timeout); end
      for (int i = 0; i < 10; i++) step(1, 1023);
      checks++; if (dut_beats != 0) begin errors++; $display("FAIL reset_unarmed beats got %0d want 0", dut_beats); end
      step(1, 150);
      step(1, 800);
      checks++; if (dut_beats != 1) begin errors++; $display("FAIL reset_first_beat beats got %0d want 1", dut_beats); end
      checks++; if (bus.interval !== '0) begin errors++; $display("FAIL reset_first_records interval got %0d want 0", bus.interval); end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL reset_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   task automatic test_periodic();
      do_reset(2);
      base(5);
      for (int p = 0; p < 6; p++) begin
         peak();
         checks++; if (bus.beat !== 1'b1) begin errors++; $display("FAIL periodic_beat%0d got %0b want 1", p, bus.beat); end
         if (p >= 1) begin
            checks++; if (bus.interval !== CW'(100)) begin errors++; $display("FAIL periodic_interval%0d got %0d want 100", p, bus.interval); end
         end
         base(1);
         checks++; if (bus.avg_valid !== (p >= 4)) begin errors++; $display("FAIL periodic_avg_valid%0d got %0b want %0b", p, bus.avg_valid, p >= 4); end
         if (p >= 4) begin
            checks++; if (bus.avg_interval !== CW'(100)) begin errors++; $display("FAIL periodic_avg%0d got %0d want 100", p, bus.avg_interval); end
         end
         base(98);
      end
      checks++; if (dut_beats != 6) begin errors++; $display("FAIL periodic_count got %0d want 6", dut_beats); end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL periodic_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   task automatic test_hysteresis();
      do_reset(2);
      base(3); peak(); base(99); peak();
      for (int i = 1; i <= 40; i++) step(1, (i % 2) ? 650 : 150);
      base(4);
      step(1, 800);
      checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL refract_no_beat got %0b want 0", bus.beat); end
      for (int i = 46; i < 60; i++) step(1, 150);
      step(1, 800);
      checks++; if (bus.beat !== 1'b1) begin errors++; $display("FAIL refract_rearm_beat got %0b want 1", bus.beat); end
      checks++; if (bus.interval !== CW'(60)) begin errors++; $display("FAIL refract_interval got %0d want 60", bus.interval); end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL refract_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   task automatic test_truncation();
      int iv[5];
      int ea[5];
      int extra;
      iv = '{100, 101, 101, 101, 104};
      ea = '{0, 0, 0, 100, 101};
      extra = 0;
      do_reset(2);
      base(3); peak();
      for (int k = 0; k < 5; k++) begin
         base(iv[k] - 1 - extra);
         peak();
         checks++; if (bus.interval !== CW'(iv[k])) begin errors++; $display("FAIL trunc_interval%0d got %0d want %0d", k, bus.interval, iv[k]); end
         base(1);
         extra = 1;
         checks++; if (bus.avg_interval !== CW'(ea[k])) begin errors++; $display("FAIL trunc_avg%0d got %0d want %0d", k, bus.avg_interval, ea[k]); end
      end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL trunc_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   task automatic test_timeout();
      do_reset(2);
      base(3); peak();
      for (int k = 0; k < 4; k++) begin base(59); peak(); end
      base(1);
      checks++; if (bus.avg_valid !== 1'b1 || bus.avg_interval !== CW'(60)) begin errors++; $display("FAIL timeout_pre_avg got %0b/%0d want 1/60", bus.avg_valid, bus.avg_interval); end
      base(253);
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %0b want 0", bus.timeout); end
      base(1);
      checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL timeout_assert got %0b want 1", bus.timeout); end
      checks++; if (bus.avg_valid !== 1'b0 || bus.avg_interval !== '0) begin errors++; $display("FAIL timeout_avg_clear got %0b/%0d want 0/0", bus.avg_valid, bus.avg_interval); end
      peak();
      checks++; if (bus.beat !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear beat/timeout got %0b/%0b want 1/0", bus.beat, bus.timeout); end
      checks++; if (bus.interval !== CW'(60)) begin errors++; $display("FAIL timeout_no_record got %0d want 60", bus.interval); end
      base(79); peak();
      checks++; if (bus.interval !== CW'(80)) begin errors++; $display("FAIL timeout_next_interval got %0d want 80", bus.interval); end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL timeout_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   task automatic test_gapped();
      do_reset(2);
      for (int i = 0; i < 2; i++) gstep($urandom_range(0, lo));
      gstep($urandom_range(hi, 1023));
      for (int i = 0; i < 69; i++) gstep($urandom_range(0, lo));
      gstep($urandom_range(hi, 1023));
      checks++; if (bus.interval !== CW'(70)) begin errors++; $display("FAIL gapped_interval got %0d want 70", bus.interval); end
      for (int i = 0; i < 10; i++) gstep($urandom_range(0, lo));
      rst_cycle(1);
      checks++; if ({bus.beat, bus.interval, bus.avg_interval, bus.avg_valid, bus.timeout} !== '0) begin
         errors++; $display("FAIL midop_reset outputs got %0b/%0d/%0d/%0b/%0b want all 0", bus.beat, bus.interval, bus.avg_interval, bus.avg_valid, bus.timeout);
      end
      step(1, 800);
      checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL midop_idle beat got %0b want 0", bus.beat); end
      base(1); peak();
      checks++; if (bus.beat !== 1'b1 || bus.interval !== '0) begin errors++; $display("FAIL midop_first beat/interval got %0b/%0d want 1/0", bus.beat, bus.interval); end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL gapped_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   task automatic test_inverted_thresh();
      lo = 300; hi = 150;
      do_reset(2);
      step(1, 200);
      checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL inverted_arm_sample beat got %0b want 0", bus.beat); end
      step(1, 200);
      checks++; if (bus.beat !== 1'b1) begin errors++; $display("FAIL inverted_next_sample beat got %0b want 1", bus.beat); end
      lo = 200; hi = 600;
   endtask

   task automatic test_random();
      int kind, per, len;
      do_reset(2);
      for (int seg = 0; seg < 30; seg++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            for (int i = 0; i < 100; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 1023));
         end else if (kind == 1) begin
            per = $urandom_range(52, 150);
            for (int r = 0; r < 3; r++) begin
               for (int i = 0; i < per - 1; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, lo));
               step(1, $urandom_range(hi, 1023));
            end
         end else begin
            len = $urandom_range(240, 300);
            for (int i = 0; i < len; i++) step($urandom_range(0, 7) != 0, $urandom_range(0, hi - 1));
         end
      end
      checks++; if (dut_beats != mdl_beats) begin errors++; $display("FAIL random_beat_count got %0d want %0d", dut_beats, mdl_beats); end
      checks++; if (dev_cnt != 0) begin errors++; $display("FAIL random_model deviations got %0d want 0 (first at %0t)", dev_cnt, dev_t); end
   endtask

   initial begin
      reset = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample = '0;
      bus.thresh_lo = DW'(lo);
      bus.thresh_hi = DW'(hi);
      dev_cnt = 0; dut_beats = 0; mdl_beats = 0; dev_t = 0;
      model_reset();
      test_reset();
      test_periodic();
      test_hysteresis();
      test_truncation();
      test_timeout();
      test_gapped();
      test_inverted_thresh();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
